cellrv32_trng_pool: RTL and testbench
=====================================

// Module: cellrv32_trng_pool
// PURPOSE
//   Second-generation TRNG front end. Takes 8-bit samples from an external entropy core, runs a repetition-count health test and packs bytes into DATA_WIDTH words.
//   Words are buffered in an internal FIFO random pool. Exposes CTRL/DATA registers on the IO bus and a level interrupt.
//   Sits between the ring-oscillator entropy core (driven by src_en_o) and the processor IO bus.
// PARAMETERS
//   BASE_ADDR   32'hFFFFFFB8  module base; decode addr_i[31:3], addr_i[2]=0 CTRL, 1 DATA
//   DATA_WIDTH  32            pool word width; 8, 16 or 32 only (else elaboration $error)
//   FIFO_DEPTH  4             pool entries; power of two, >=1 (else elaboration $error)
//   RCT_CUTOFF  8             identical consecutive samples that declare a health fault; 2..255
// PORTS
//   clk_i        in   1           clock, rising edge
//   rstn_i       in   1           reset, synchronous, active-low
//   addr_i       in   32          bus address
//   rden_i       in   1           bus read strobe
//   wren_i       in   1           bus write strobe
//   data_i       in   32          bus write data
//   data_o       out  32          bus read data, 0 when not reading
//   ack_o        out  1           bus acknowledge
//   src_en_o     out  1           enable to entropy core
//   src_data_i   in   8           entropy sample
//   src_valid_i  in   1           sample valid, one-cycle qualifier
//   irq_o        out  1           level interrupt
// BEHAVIOUR
//   Reset (rstn_i=0 at clk edge): all outputs 0; state OFF; FIFO empty; all CTRL bits 0.
//   CTRL (r/w): [0] en; [1] clr (w-only, reads 0, one-cycle pulse); [2] irq_en; [29] fault (r, write 1 clears);
//     [30] full (r); [31] avail (r).
//   DATA (r): FIFO head zero-extended to 32 bits. Pops when avail=1. Returns 0 with no pop when empty. Writes ignored but acked.
//   Bus: ack_o=1 exactly one cycle after any decoded rden_i/wren_i. data_o registered, same cycle as ack_o, 0 otherwise.
//   FSM:
//     OFF  : src_en_o=0; FIFO and assembler held clear.
//            en=1 -> FILL.
//     FILL : src_en_o=1; each src_valid_i sample feeds the RCT and the assembler.
//            RCT hit -> FAULT; en=0 -> OFF.
//     FAULT: src_en_o=0; fault=1; samples ignored; assembler cleared; existing FIFO words stay readable.
//            Writing CTRL with [29]=1 and [0]=1 -> FILL with RCT reset. en=0 -> OFF; fault stays sticky until written 1.
//   RCT: keep last sample and a run counter. Equal sample increments the counter; different sample resets it to 1.
//     Counter reaching RCT_CUTOFF: the faulting byte is discarded and the state moves to FAULT next cycle.
//   Assembler:
//     Samples fill the word LSB-first (first byte -> [7:0]). byte_cnt counts 0..DATA_WIDTH/8-1.
//     On the last byte the word is pushed next cycle and byte_cnt wraps to 0.
//     Push when FIFO full: word dropped silently, no stall. Fullness is judged before any same-cycle pop.
//   FIFO:
//     Push and pop in the same cycle both take effect.
//     clr=1 or state OFF empties the FIFO and resets the assembler; this beats a same-cycle push or pop.
//   irq_o = irq_en & (avail | fault), registered, one cycle after the cause.
// TESTING
//   1 Reset: after rstn_i=0 -> outputs 0; CTRL read = 32'h0; DATA read = 0.
//   2 Fill: write CTRL=0x1; feed 0x11,0x22,0x33,0x44 -> avail=1.
//     DATA read = 32'h44332211; next CTRL read has avail=0.
//   3 Overflow: DEPTH=4; feed 20 distinct bytes (5 words), no reads -> full=1.
//     Reads return words 1..4 in order; word 5 is lost; 5th DATA read = 0.
//   4 Health: RCT_CUTOFF=8; feed 0xA5 x8 -> fault=1, src_en_o=0, irq_o=1 if irq_en=1.
//     Write CTRL=0x2000_0001 -> fault=0, src_en_o=1.
//   5 Simultaneous: FIFO holds 3 words; DATA read in the same cycle as a push -> level stays 3, head advances.
//     clr pulse in the same cycle as a push -> FIFO empty.
//   6 Disable mid-word: after 2 bytes write CTRL=0 then 0x1.
//     Next 4 bytes 0x01..0x04 -> DATA = 32'h04030201.

Source files
------------

// File: rtl/cellrv32_trng_pool.sv
`timescale 1ns/1ps
// TRNG front end: repetition-count health test, byte-to-word packing and a FIFO
// random pool, exposed as CTRL/DATA registers on the IO bus with a level interrupt.
module cellrv32_trng_pool #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFFFFB8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RCT_CUTOFF = 8
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] addr_i,
    input  logic        rden_i,
    input  logic        wren_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        src_en_o,
    input  logic [7:0]  src_data_i,
    input  logic        src_valid_i,
    output logic        irq_o
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned BCNT_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1);

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_width
        $error("cellrv32_trng_pool: DATA_WIDTH must be 8, 16 or 32");
    end
    if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cellrv32_trng_pool: FIFO_DEPTH must be a power of two");
    end
    if (RCT_CUTOFF < 2 || RCT_CUTOFF > 255) begin : g_bad_cutoff
        $error("cellrv32_trng_pool: RCT_CUTOFF must be 2..255");
    end

    typedef enum logic [1:0] {ST_OFF, ST_FILL, ST_FAULT} state_t;

    state_t state, state_nxt;
    logic   en, irq_en, fault;

    // Bus decode
    logic sel, ctrl_wr, data_rd, clr, fault_wr;
    assign sel      = (addr_i[31:3] == BASE_ADDR[31:3]);
    assign ctrl_wr  = sel & wren_i & ~addr_i[2];
    assign data_rd  = sel & rden_i & addr_i[2];
    assign clr      = ctrl_wr & data_i[1];
    assign fault_wr = ctrl_wr & data_i[29];

    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], data_i[31:30], data_i[28:3]};

    // Repetition-count test
    logic [7:0] last_sample, run_cnt, run_nxt;
    logic       sample, rct_hit, take;
    assign sample  = (state == ST_FILL) & en & src_valid_i;
    assign run_nxt = (src_data_i == last_sample && run_cnt != 8'd0) ? run_cnt + 8'd1 : 8'd1;
    assign rct_hit = sample & (run_nxt == 8'(RCT_CUTOFF));
    assign take    = sample & ~rct_hit;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            last_sample <= '0;
            run_cnt     <= '0;
        end else if (state != ST_FILL) begin
            run_cnt <= '0;
        end else if (sample) begin
            last_sample <= src_data_i;
            run_cnt     <= rct_hit ? 8'd0 : run_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF:   if (en) state_nxt = ST_FILL;
            ST_FILL:  if (!en) state_nxt = ST_OFF;
                      else if (rct_hit) state_nxt = ST_FAULT;
            ST_FAULT: if (fault_wr && data_i[0]) state_nxt = ST_FILL;
                      else if (!en) state_nxt = ST_OFF;
            default:  state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state    <= ST_OFF;
            src_en_o <= 1'b0;
            en       <= 1'b0;
            irq_en   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            src_en_o <= (state_nxt == ST_FILL);
            if (ctrl_wr) begin
                en     <= data_i[0];
                irq_en <= data_i[2];
            end
            if (rct_hit) fault <= 1'b1;
            else if (fault_wr) fault <= 1'b0;
        end
    end

    // Assembler: LSB-first packing, completed word pushed the following cycle
    logic [DATA_WIDTH-1:0] asm_word;
    logic [BCNT_W-1:0]     byte_cnt;
    logic                  push_req, flush;
    assign flush = clr | (state == ST_OFF);

    always_ff @(posedge clk_i) begin
        if (!rstn_i || flush || state == ST_FAULT) begin
            asm_word <= '0;
            byte_cnt <= '0;
            push_req <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (take) begin
                asm_word[{byte_cnt, 3'b000} +: 8] <= src_data_i;
                if (byte_cnt == BCNT_W'(NUM_BYTES - 1)) begin
                    byte_cnt <= '0;
                    push_req <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

    // Random pool
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  full, avail, push, pop;
    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign avail = (level != '0);
    assign push  = push_req & ~full;
    assign pop   = data_rd & avail;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (FIFO_DEPTH == 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rstn_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wr_ptr] <= asm_word;
    end

    // Registered bus response and interrupt
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ack_o  <= 1'b0;
            data_o <= '0;
            irq_o  <= 1'b0;
        end else begin
            ack_o  <= sel & (rden_i | wren_i);
            data_o <= '0;
            if (sel && rden_i) begin
                if (addr_i[2]) data_o <= avail ? 32'(mem[rd_ptr]) : 32'd0;
                else           data_o <= {avail, full, fault, 26'd0, irq_en, 1'b0, en};
            end
            irq_o <= irq_en & (avail | fault);
        end
    end

endmodule

// File: tb/tb_cellrv32_trng_pool.sv
`timescale 1ns/1ps
// Directed bench for cellrv32_trng_pool: a byte-level model queues expected pool
// words as samples are fed; DATA reads pop and compare against that queue.
module tb_cellrv32_trng_pool;
    localparam logic [31:0] CTRL_A = 32'hFFFFFFB8;
    localparam logic [31:0] DATA_A = 32'hFFFFFFBC;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] addr = '0;
    logic        rden = 1'b0;
    logic        wren = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        src_en;
    logic [7:0]  src_data = '0;
    logic        src_valid = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_asm = '0;
    int          m_cnt = 0;
    logic [31:0] d;

    always #5 clk = ~clk;

    cellrv32_trng_pool dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .addr_i      (addr),
        .rden_i      (rden),
        .wren_i      (wren),
        .data_i      (wdata),
        .data_o      (rdata),
        .ack_o       (ack),
        .src_en_o    (src_en),
        .src_data_i  (src_data),
        .src_valid_i (src_valid),
        .irq_o       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_asm = {b, m_asm[31:8]};
        m_cnt++;
        if (m_cnt == 4) begin
            m_cnt = 0;
            if (exp_q.size() < 4) exp_q.push_back(m_asm);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        m_cnt = 0;
        m_asm = '0;
    endtask

    task automatic bus_write(input string tag, input logic [31:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        addr = a; wdata = v; wren = 1'b1;
        @(posedge clk); #1;
        wren = 1'b0;
        check(tag, 32'(ack), 32'd1);
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic exp_ack,
                            output logic [31:0] v);
        @(posedge clk); #1;
        addr = a; rden = 1'b1;
        @(posedge clk); #1;
        rden = 1'b0;
        check(tag, 32'(ack), 32'(exp_ack));
        v = rdata;
    endtask

    task automatic read_ctrl(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(tag, CTRL_A, 1'b1, v);
        check(tag, v, exp);
    endtask

    task automatic read_data(input string tag);
        logic [31:0] v, exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
        bus_read(tag, DATA_A, 1'b1, v);
        check(tag, v, exp);
    endtask

    task automatic feed(input logic [7:0] b, input bit modelled);
        @(posedge clk); #1;
        src_data = b; src_valid = 1'b1;
        @(posedge clk); #1;
        src_valid = 1'b0;
        if (modelled) model_byte(b);
    endtask

    initial begin
        // Reset
        idle(3);
        check("rst_data_o", rdata, 32'd0);
        check("rst_flags", {29'd0, ack, src_en, irq}, 32'd0);
        rstn = 1'b1;
        idle(1);
        read_ctrl("rst_ctrl", 32'h0);
        read_data("rst_data");
        bus_read("unmapped_ack", 32'h0000_0010, 1'b0, d);
        check("unmapped_data", d, 32'd0);

        // Fill one word
        bus_write("en_wr", CTRL_A, 32'h1);
        bus_write("data_wr_ack", DATA_A, 32'hDEADBEEF);
        idle(2);
        check("fill_src_en", 32'(src_en), 32'd1);
        feed(8'h11, 1); feed(8'h22, 1); feed(8'h33, 1); feed(8'h44, 1);
        idle(2);
        read_ctrl("fill_ctrl_avail", 32'h8000_0001);
        check("fill_model_word", exp_q[0], 32'h44332211);
        read_data("fill_data");
        read_ctrl("fill_ctrl_empty", 32'h0000_0001);

        // Overflow: 5 words into a 4-deep pool
        for (int i = 1; i <= 20; i++) feed(8'(i), 1);
        idle(2);
        read_ctrl("ovf_ctrl_full", 32'hC000_0001);
        for (int i = 0; i < 5; i++) read_data($sformatf("ovf_data%0d", i));
        read_ctrl("ovf_ctrl_empty", 32'h0000_0001);

        // Pop in the same cycle as a push
        for (int i = 8'h21; i <= 8'h2F; i++) feed(8'(i), 1);
        @(posedge clk); #1;
        src_data = 8'h30; src_valid = 1'b1;
        @(posedge clk); #1;
        src_valid = 1'b0; addr = DATA_A; rden = 1'b1;
        @(posedge clk); #1;
        rden = 1'b0;
        check("simul_ack", 32'(ack), 32'd1);
        check("simul_head", rdata, exp_q.pop_front());
        model_byte(8'h30);
        idle(1);
        read_ctrl("simul_ctrl", 32'h8000_0001);
        for (int i = 0; i < 4; i++) read_data($sformatf("simul_data%0d", i));

        // clr in the same cycle as a push
        for (int i = 8'h41; i <= 8'h44; i++) feed(8'(i), 1);
        for (int i = 8'h31; i <= 8'h33; i++) feed(8'(i), 1);
        @(posedge clk); #1;
        src_data = 8'h34; src_valid = 1'b1;
        @(posedge clk); #1;
        src_valid = 1'b0; addr = CTRL_A; wdata = 32'h3; wren = 1'b1;
        @(posedge clk); #1;
        wren = 1'b0;
        check("clr_ack", 32'(ack), 32'd1);
        model_byte(8'h34);
        model_flush();
        idle(1);
        read_ctrl("clr_ctrl", 32'h0000_0001);
        read_data("clr_data");

        // Disable mid-word
        feed(8'hAA, 1); feed(8'hBB, 1);
        bus_write("dis_wr0", CTRL_A, 32'h0);
        model_flush();
        idle(1);
        check("dis_src_en", 32'(src_en), 32'd0);
        bus_write("dis_wr1", CTRL_A, 32'h1);
        idle(2);
        feed(8'h01, 1); feed(8'h02, 1); feed(8'h03, 1); feed(8'h04, 1);
        idle(2);
        check("dis_model_word", exp_q[0], 32'h04030201);
        read_data("dis_data");

        // Health test: 8 identical samples trip the RCT
        bus_write("hlt_wr_irq", CTRL_A, 32'h5);
        idle(3);
        check("hlt_irq_idle", 32'(irq), 32'd0);
        check("hlt_src_en_on", 32'(src_en), 32'd1);
        for (int i = 0; i < 7; i++) feed(8'hA5, 1);
        feed(8'hA5, 0);
        m_cnt = 0; m_asm = '0;
        idle(2);
        check("hlt_src_en_off", 32'(src_en), 32'd0);
        read_ctrl("hlt_ctrl_fault", 32'hA000_0005);
        read_data("hlt_data");
        idle(3);
        check("hlt_irq_fault", 32'(irq), 32'd1);
        bus_write("hlt_clear", CTRL_A, 32'h2000_0005);
        idle(2);
        check("hlt_src_en_resume", 32'(src_en), 32'd1);
        read_ctrl("hlt_ctrl_clear", 32'h0000_0005);
        idle(2);
        check("hlt_irq_clear", 32'(irq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
